hit_arbiter: RTL

Frame-rate hit scheduler between the two players' collision outputs and each player's hit_FSM. Each frame it decides which overlaps become hits, resolves simultaneous trades and clashes, enforces per-attack rehit lockout, and sequences KO → respawn → invulnerability per player. It drives each hit_FSM's got_hit, hit_damage_in and offscreen inputs.

---
 rtl/hit_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hit_arbiter.sv
// hit_arbiter: frame-rate hit scheduler between two players' collision
// outputs and their hit_FSMs (hits, trades, clashes, lockout, KO/respawn).
// Ports: clk; reset (async, active-low); frame_tick (one pulse per frame);
//   pN_overlap, pN_attack_dmg[5:0], pN_attack_start, pN_offscreen in;
//   pN_got_hit, pN_hit_damage[5:0], pN_ko, pN_respawn_active,
//   pN_invuln, clash out.  Index 0 is P1, index 1 is P2.
module hit_arbiter #(
   parameter int unsigned LOCKOUT_FRAMES = 12,
   parameter int unsigned RESPAWN_FRAMES = 60,
   parameter int unsigned INVULN_FRAMES  = 120,
   parameter int unsigned CLASH_THRESH   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       p1_overlap,
   input  logic [5:0] p1_attack_dmg,
   input  logic       p1_attack_start,
   input  logic       p2_overlap,
   input  logic [5:0] p2_attack_dmg,
   input  logic       p2_attack_start,
   input  logic       p1_offscreen,
   input  logic       p2_offscreen,
   output logic       p1_got_hit,
   output logic       p2_got_hit,
   output logic [5:0] p1_hit_damage,
   output logic [5:0] p2_hit_damage,
   output logic       p1_ko,
   output logic       p2_ko,
   output logic       p1_respawn_active,
   output logic       p2_respawn_active,
   output logic       p1_invuln,
   output logic       p2_invuln,
   output logic       clash
);

   localparam logic [1:0] ST_VULN = 2'd0;
   localparam logic [1:0] ST_LOCK = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_INV  = 2'd3;

   localparam logic [7:0] LOCK_LD = 8'(LOCKOUT_FRAMES);
   localparam logic [7:0] RESP_LD = 8'(RESPAWN_FRAMES);
   localparam logic [7:0] INV_LD  = 8'(INVULN_FRAMES);

   localparam bit PARAMS_OK =
      (LOCKOUT_FRAMES >= 1) && (LOCKOUT_FRAMES <= 255) &&
      (RESPAWN_FRAMES >= 1) && (RESPAWN_FRAMES <= 255) &&
      (INVULN_FRAMES  >= 1) && (INVULN_FRAMES  <= 255);

   // Per-victim state, indexed by victim.
   logic [1:0][1:0] state_q, state_d;
   logic [1:0][7:0] cnt_q, cnt_d;
   logic [1:0][5:0] dmg_q, dmg_d;
   logic [1:0]      got_q, got_d;
   logic [1:0]      ko_q, ko_d;
   logic            clash_q, clash_d;
   // Start latches, indexed by attacking player.
   logic [1:0]      start_q, start_d;

   logic [1:0]      start_eff;
   logic [1:0]      offs;
   // Attacker-side views, indexed by victim.
   logic [1:0]      atk_ovl;
   logic [1:0]      atk_start;
   logic [1:0][5:0] atk_dmg;

   logic [1:0]      lock_exit;
   logic [1:0]      hit_req;
   logic [5:0]      dmg_diff;
   logic            is_clash;

   always_comb begin
      start_eff = start_q | {p2_attack_start, p1_attack_start};
      offs      = {p2_offscreen, p1_offscreen};
      atk_ovl   = {p1_overlap, p2_overlap};
      atk_start = {start_eff[0], start_eff[1]};
      atk_dmg   = {p1_attack_dmg, p2_attack_dmg};
      lock_exit = '0;
      hit_req   = '0;
      for (int v = 0; v < 2; v++) begin
         // Lockout ends when the count runs out or the attacker starts
         // a new attack; that same tick may already land the new hit.
         lock_exit[v] = (state_q[v] == ST_LOCK) &&
                        ((cnt_q[v] <= 8'd1) || atk_start[v]);
         hit_req[v]   = ((state_q[v] == ST_VULN) || lock_exit[v]) &&
                        !offs[v] && atk_ovl[v];
      end
      dmg_diff = (p1_attack_dmg >= p2_attack_dmg) ?
                 (p1_attack_dmg - p2_attack_dmg) :
                 (p2_attack_dmg - p1_attack_dmg);
      is_clash = (&hit_req) && (32'(dmg_diff) <= CLASH_THRESH);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dmg_d   = dmg_q;
      got_d   = '0;
      ko_d    = '0;
      clash_d = frame_tick && is_clash;
      start_d = frame_tick ? 2'b00 : start_eff;
      if (frame_tick) begin
         for (int v = 0; v < 2; v++) begin
            if (offs[v] && (state_q[v] != ST_RESP)) begin
               // Leaving the blast zone outranks any hit this frame.
               ko_d[v]    = 1'b1;
               state_d[v] = ST_RESP;
               cnt_d[v]   = RESP_LD;
            end else if (hit_req[v]) begin
               state_d[v] = ST_LOCK;
               cnt_d[v]   = LOCK_LD;
               if (!is_clash) begin
                  got_d[v] = 1'b1;
                  dmg_d[v] = atk_dmg[v];
               end
            end else begin
               case (state_q[v])
                  ST_LOCK: begin
                     if (lock_exit[v]) begin
                        state_d[v] = ST_VULN;
                        cnt_d[v]   = 8'd0;
                     end else begin
                        cnt_d[v] = cnt_q[v] - 8'd1;
                     end
                  end
                  ST_RESP: begin
                     if (cnt_q[v] <= 8'd1) begin
                        state_d[v] = ST_INV;
                        cnt_d[v]   = INV_LD;
                     end else begin
                        cnt_d[v] = cnt_q[v] - 8'd1;
                     end
                  end
                  ST_INV: begin
                     if (cnt_q[v] <= 8'd1) begin
                        state_d[v] = ST_VULN;
                        cnt_d[v]   = 8'd0;
                     end else begin
                        cnt_d[v] = cnt_q[v] - 8'd1;
                     end
                  end
                  default: begin
                     state_d[v] = state_q[v];
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= {ST_VULN, ST_VULN};
         cnt_q   <= '0;
         dmg_q   <= '0;
         got_q   <= '0;
         ko_q    <= '0;
         clash_q <= 1'b0;
         start_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dmg_q   <= dmg_d;
         got_q   <= got_d;
         ko_q    <= ko_d;
         clash_q <= clash_d;
         start_q <= start_d;
      end
   end

   assign p1_got_hit        = got_q[0];
   assign p2_got_hit        = got_q[1];
   assign p1_hit_damage     = dmg_q[0];
   assign p2_hit_damage     = dmg_q[1];
   assign p1_ko             = ko_q[0];
   assign p2_ko             = ko_q[1];
   assign clash             = clash_q;
   assign p1_respawn_active = (state_q[0] == ST_RESP);
   assign p2_respawn_active = (state_q[1] == ST_RESP);
   assign p1_invuln         = (state_q[0] == ST_RESP) ||
                              (state_q[0] == ST_INV);
   assign p2_invuln         = (state_q[1] == ST_RESP) ||
                              (state_q[1] == ST_INV);

   // Frame counts of zero or above the 8-bit counter range are illegal.
   a_params_ok: assert property (@(posedge clk) PARAMS_OK)
      else $error("hit_arbiter: frame parameters must be 1..255");

endmodule
